// File: rtl/mskaes_key_loader_pkg.sv
// Shared definitions for the masked key loader.
// Contents:
//   - key-size mode encodings
//   - per-mode word counts
//   - the loader FSM state type
//   - small decode helpers for mode flags and the last word index
package mskaes_key_loader_pkg;

   localparam logic [1:0] KMODE_128 = 2'b00;
   localparam logic [1:0] KMODE_192 = 2'b01;
   localparam logic [1:0] KMODE_256 = 2'b10;

   localparam int unsigned NW_128 = 4;
   localparam int unsigned NW_192 = 6;
   localparam int unsigned NW_256 = 8;

   typedef enum logic {
      LOAD = 1'b0,
      HOLD = 1'b1
   } kl_state_e;

   // The reserved encoding 11 behaves as 256.
   function automatic logic mode_is_256(input logic [1:0] m);
      return (m == KMODE_256) || (m == 2'b11);
   endfunction

   function automatic logic mode_is_192(input logic [1:0] m);
      return (m == KMODE_192);
   endfunction

   // Index of the final word for the given mode flags.
   function automatic logic [2:0] last_index(input logic is_256, input logic is_192);
      if (is_256)
         return 3'(NW_256 - 1);
      else if (is_192)
         return 3'(NW_192 - 1);
      else
         return 3'(NW_128 - 1);
   endfunction

endpackage

// File: rtl/mskaes_key_word_slot.sv
// One shared key word of storage.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset (clears to all-zero sharing)
//   clr  - synchronous clear (zeroization), wins over load
//   load - write enable
//   din  - shared word in, W bits
//   q    - stored shared word, W bits
// Every bit is stored independently; no mixing between shares.
module mskaes_key_word_slot #(
   parameter int unsigned W = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         load,
   input  logic [W-1:0] din,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (rst || clr)
         q <= '0;
      else if (load)
         q <= din;
   end

endmodule

// File: rtl/mskaes_key_loader.sv
// Masked key loader.
// Collects the shared cipher key as 32*d-bit shared words and presents the
// assembled 256*d-bit shared key to the core. Storage is zeroized once the
// core has taken the key, or on flush.
// Ports:
//   clk, rst         - clock, synchronous active-high reset
//   flush            - synchronous abort: zeroize, back to LOAD
//   in_mode[1:0]     - key size, sampled with the first word
//   in_valid/in_ready- input word handshake
//   in_data          - shared key word, byte b at [8*d*b +: 8*d]
//   out_valid/out_ready - key handoff handshake
//   sh_key           - assembled shared key, word w at [32*d*w +: 32*d]
//   out_mode_256/192 - latched mode flags
module mskaes_key_loader
   import mskaes_key_loader_pkg::*;
#(
   parameter int unsigned d = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic [1:0]        in_mode,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [32*d-1:0]   in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [256*d-1:0]  sh_key,
   output logic              out_mode_256,
   output logic              out_mode_192
);

   kl_state_e   state;
   logic [2:0]  cnt;
   logic        mode_256_q;
   logic        mode_192_q;

   logic        accept;
   logic        consume;
   logic        slot_clr;
   logic        cur_256;
   logic        cur_192;
   logic [2:0]  last_idx;

   // Handshake flags decode from the state register only.
   assign in_ready  = (state == LOAD);
   assign out_valid = (state == HOLD);

   assign accept   = in_valid  && in_ready;
   assign consume  = out_valid && out_ready;
   assign slot_clr = flush || consume;

   // On the first word the mode comes straight from in_mode; afterwards
   // the latched flags decide when the load is complete.
   always_comb begin
      cur_256 = mode_256_q;
      cur_192 = mode_192_q;
      if (cnt == 3'd0) begin
         cur_256 = mode_is_256(in_mode);
         cur_192 = mode_is_192(in_mode);
      end
      last_idx = last_index(cur_256, cur_192);
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         state      <= LOAD;
         cnt        <= '0;
         mode_256_q <= 1'b0;
         mode_192_q <= 1'b0;
      end else begin
         case (state)
            LOAD: begin
               if (accept) begin
                  if (cnt == 3'd0) begin
                     mode_256_q <= cur_256;
                     mode_192_q <= cur_192;
                  end
                  if (cnt == last_idx) begin
                     state <= HOLD;
                     cnt   <= '0;
                  end else begin
                     cnt <= cnt + 3'd1;
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state      <= LOAD;
                  mode_256_q <= 1'b0;
                  mode_192_q <= 1'b0;
               end
            end
            default: state <= LOAD;
         endcase
      end
   end

   assign out_mode_256 = mode_256_q;
   assign out_mode_192 = mode_192_q;

   for (genvar w = 0; w < 8; w++) begin : g_slot
      mskaes_key_word_slot #(
         .W(32*d)
      ) u_slot (
         .clk  (clk),
         .rst  (rst),
         .clr  (slot_clr),
         .load (accept && (cnt == 3'(w))),
         .din  (in_data),
         .q    (sh_key[32*d*w +: 32*d])
      );
   end

endmodule

// File: tb/tb_mskaes_key_loader.sv
module tb_mskaes_key_loader;

   logic         clk = 1'b0;
   logic         rst;
   logic         flush;
   logic [1:0]   in_mode;
   logic         in_valid;
   logic         in_ready;
   logic [63:0]  in_data;
   logic         out_valid;
   logic         out_ready;
   logic [511:0] sh_key;
   logic         out_mode_256;
   logic         out_mode_192;

   int checks   = 0;
   int failures = 0;
   logic [511:0] exp_raw;

   always #5 clk = ~clk;

   mskaes_key_loader #(.d(2)) dut (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .in_mode      (in_mode),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .sh_key       (sh_key),
      .out_mode_256 (out_mode_256),
      .out_mode_192 (out_mode_192)
   );

   task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Byte b of a word: share0 = mask byte, share1 = key byte ^ mask byte.
   function automatic logic [63:0] share_word(input logic [31:0] kw, input logic [31:0] m);
      logic [63:0] r;
      for (int b = 0; b < 4; b++) begin
         r[16*b +: 8]     = m[8*b +: 8];
         r[16*b + 8 +: 8] = kw[8*b +: 8] ^ m[8*b +: 8];
      end
      return r;
   endfunction

   function automatic logic [255:0] recomb(input logic [511:0] s);
      logic [255:0] r;
      for (int j = 0; j < 32; j++)
         r[8*j +: 8] = s[16*j +: 8] ^ s[16*j + 8 +: 8];
      return r;
   endfunction

   function automatic logic [255:0] ref_key(input int nw, input int base);
      logic [255:0] r;
      r = '0;
      for (int j = 0; j < 4*nw; j++)
         r[8*j +: 8] = 8'(base + j);
      return r;
   endfunction

   function automatic logic [31:0] key_word(input int w, input int base);
      logic [31:0] r;
      for (int b = 0; b < 4; b++)
         r[8*b +: 8] = 8'(base + 4*w + b);
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present word w (bounded wait on in_ready), then idle for gap cycles.
   task automatic send(input int w, input int base, input logic [1:0] mode, input int gap);
      int n;
      in_data  = share_word(key_word(w, base), $urandom);
      exp_raw[64*w +: 64] = in_data;
      in_mode  = mode;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 20) begin
         tick();
         n++;
      end
      if (n == 20) check("in_ready_wait", 512'(in_ready), 512'(1));
      tick();
      in_valid = 1'b0;
      in_mode  = 2'($urandom);
      repeat (gap) tick();
   endtask

   task automatic take_key(input string tag);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      exp_raw = '0;
      check({tag, "_zero_key"},  sh_key, '0);
      check({tag, "_ov_low"},    512'(out_valid), 512'(0));
      check({tag, "_ir_high"},   512'(in_ready), 512'(1));
      check({tag, "_flags_clr"}, 512'({out_mode_256, out_mode_192}), 512'(0));
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; in_mode = 2'b00; in_valid = 1'b0;
      in_data = '0; out_ready = 1'b0; exp_raw = '0;
      tick(); tick();
      rst = 1'b0;

      // reset state
      check("rst_in_ready",  512'(in_ready), 512'(1));
      check("rst_out_valid", 512'(out_valid), 512'(0));
      check("rst_sh_key",    sh_key, '0);
      check("rst_flags",     512'({out_mode_256, out_mode_192}), 512'(0));

      // AES-128, back-to-back words, out_ready held low
      for (int w = 0; w < 4; w++) begin
         send(w, 0, 2'b00, 0);
         if (w == 2) check("k128_ov_early", 512'(out_valid), 512'(0));
      end
      check("k128_ov", 512'(out_valid), 512'(1));
      repeat (3) tick();
      check("k128_ov_held", 512'(out_valid), 512'(1));
      check("k128_ir_low",  512'(in_ready), 512'(0));
      check("k128_raw",     sh_key, exp_raw);
      check("k128_key",     512'(recomb(sh_key)), 512'(ref_key(4, 0)));
      check("k128_upper0",  512'(sh_key[511:256]), 512'(0));
      check("k128_flags",   512'({out_mode_256, out_mode_192}), 512'(0));
      flush = 1'b1; tick(); flush = 1'b0; exp_raw = '0;
      check("flush_hold_zero", sh_key, '0);
      check("flush_hold_ir",   512'(in_ready), 512'(1));

      // AES-256 with input gaps 0..3, junk offered during HOLD
      for (int w = 0; w < 8; w++) send(w, 0, 2'b10, w % 4);
      check("k256_ov",    512'(out_valid), 512'(1));
      check("k256_flags", 512'({out_mode_256, out_mode_192}), 512'(2));
      check("k256_key",   512'(recomb(sh_key)), 512'(ref_key(8, 0)));
      check("k256_raw",   sh_key, exp_raw);
      in_valid = 1'b1; in_data = 64'hdead_beef_cafe_f00d; in_mode = 2'b00;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("k256_hold_ir", 512'(in_ready), 512'(0));
         check("k256_hold_key", sh_key, exp_raw);
      end
      in_valid = 1'b0;
      take_key("k256_take");

      // AES-192, consume, then a second key
      for (int w = 0; w < 6; w++) send(w, 'h40, 2'b01, 0);
      check("k192_ov",    512'(out_valid), 512'(1));
      check("k192_flags", 512'({out_mode_256, out_mode_192}), 512'(1));
      check("k192_key",   512'(recomb(sh_key)), 512'(ref_key(6, 'h40)));
      check("k192_raw",   sh_key, exp_raw);
      take_key("k192_take");
      for (int w = 0; w < 4; w++) send(w, 'h80, 2'b00, 0);
      check("k2nd_ov",  512'(out_valid), 512'(1));
      check("k2nd_key", 512'(recomb(sh_key)), 512'(ref_key(4, 'h80)));
      check("k2nd_raw", sh_key, exp_raw);
      take_key("k2nd_take");

      // flush on the 3rd handshake of a 256 load
      send(0, 'h10, 2'b10, 0);
      send(1, 'h10, 2'b10, 0);
      in_data = share_word(key_word(2, 'h10), $urandom);
      in_valid = 1'b1; flush = 1'b1;
      tick();
      in_valid = 1'b0; flush = 1'b0; exp_raw = '0;
      check("fl_zero", sh_key, '0);
      check("fl_ir",   512'(in_ready), 512'(1));
      check("fl_ov",   512'(out_valid), 512'(0));
      for (int w = 0; w < 8; w++) begin
         send(w, 'h60, 2'b10, 0);
         if (w == 6) check("fl_ov_early", 512'(out_valid), 512'(0));
      end
      check("fl_new_ov",  512'(out_valid), 512'(1));
      check("fl_new_key", 512'(recomb(sh_key)), 512'(ref_key(8, 'h60)));
      check("fl_new_raw", sh_key, exp_raw);
      take_key("fl_take");

      // rst in HOLD together with out_ready
      for (int w = 0; w < 4; w++) send(w, 'hc0, 2'b00, 0);
      check("r_ov_pre", 512'(out_valid), 512'(1));
      rst = 1'b1; out_ready = 1'b1;
      tick();
      rst = 1'b0; out_ready = 1'b0; exp_raw = '0;
      check("r_ir",    512'(in_ready), 512'(1));
      check("r_ov",    512'(out_valid), 512'(0));
      check("r_key",   sh_key, '0);
      check("r_flags", 512'({out_mode_256, out_mode_192}), 512'(0));

      // reserved mode 11 on first word, in_mode toggling afterwards
      for (int w = 0; w < 8; w++) begin
         send(w, 'h20, (w == 0) ? 2'b11 : 2'(w % 4), 0);
         if (w == 3 || w == 5) check("m11_ov_early", 512'(out_valid), 512'(0));
      end
      check("m11_ov",    512'(out_valid), 512'(1));
      check("m11_flags", 512'({out_mode_256, out_mode_192}), 512'(2));
      check("m11_key",   512'(recomb(sh_key)), 512'(ref_key(8, 'h20)));
      take_key("m11_take");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mskaes_key_loader.md
# mskaes_key_loader

Masked key loader sitting directly upstream of the 32-bit key datapath. It accepts the shared cipher key as a stream of 32-bit shared words over a valid/ready handshake and assembles the 256*d-bit shared key bus that the datapath samples on `init`. It also holds the key-size mode and presents the complete key to the core controller over a second valid/ready handshake. Once the core has consumed the key, the block zeroizes its storage.

## Interface
Parameters:
- `d`, 2, number of shares; all shared buses use the codebase's share-interleaved byte layout, with byte b at [8*d*b +: 8*d].

Ports:
- `clk`  in  1  clock; single clock domain.
- `rst`  in  1  reset, synchronous, active-high.
- `flush`  in  1  synchronous abort; clears storage and returns to LOAD.
- `in_mode`  in  2  key size: 00=128, 01=192, 10=256, 11 reserved (treated as 256); sampled with the first word.
- `in_valid`  in  1  shared word valid.
- `in_ready`  out  1  loader accepts a word.
- `in_data`  in  32*d  shared key word; byte b at [8*d*b +: 8*d].
- `out_valid`  out  1  complete key available.
- `out_ready`  in  1  core has taken the key (asserted in the cycle the datapath samples with `init`=1).
- `sh_key`  out  256*d  assembled shared key; word w at [32*d*w +: 32*d].
- `out_mode_256`  out  1  latched mode is 256 (or reserved).
- `out_mode_192`  out  1  latched mode is 192.

## Operation
- FSM states:
  - LOAD: `in_ready`=1, `out_valid`=0.
  - HOLD: `in_ready`=0, `out_valid`=1.
- Word count N: 4 / 6 / 8 for modes 128 / 192 / 256.
- A word is accepted when `in_valid` & `in_ready`.
  - Word index cnt (3 bits, 0..7) selects the slot: `sh_key` word cnt <= `in_data`.
  - cnt then increments.
- When cnt==0 at acceptance, `in_mode` is latched. `in_mode` is ignored for the remaining words.
- When the accepted word has cnt==N-1: go to HOLD and reset cnt to 0.
- Slots with index >= N are never written and stay at the all-zero sharing (every share 0).
- In HOLD, when `out_valid` & `out_ready`:
  - all 8 slots clear to all-zero sharing;
  - the mode flags clear;
  - the FSM goes to LOAD.
- `flush` takes effect in either state: slots zeroed, cnt=0, mode cleared, FSM to LOAD.
- Priority: `rst` > `flush` > handshakes. A `flush` in the same cycle as an input or output handshake wins; the accepted word is discarded and no key is consumed.
- No share recombination anywhere. Each share bit is stored and routed independently. No XOR between shares, no fresh randomness. The block must preserve the share-domain isolation expected by the PINI flow.

## Timing
- Reset values:
  - `in_ready`=1, `out_valid`=0;
  - `sh_key`=0, `out_mode_256`=0, `out_mode_192`=0;
  - cnt=0, state LOAD.
- `in_ready` and `out_valid` are decoded from registered state only; no combinational path from `out_ready` or `in_valid`.
- Input side: one word per cycle while `in_valid` is held high.
- `out_valid` rises on the cycle after the last word is accepted. `sh_key` is stable for as long as `out_valid`=1.
- Zeroization is visible on `sh_key` the cycle after the output handshake. `in_ready` returns to 1 in that same cycle.
- Minimum turnaround: N input cycles + 1 output cycle per key.
- A `flush` or `rst` mid-load leaves no partial key visible on the following cycle.

## Structure
- Shared package holds:
  - mode encoding constants: `KMODE_128`, `KMODE_192`, `KMODE_256`;
  - word-count constants: 4, 6, 8;
  - the state enum: LOAD, HOLD.
- One sub-module, `mskaes_key_word_slot`: 32*d-bit register with load enable and synchronous clear; instantiated 8 times, with write-enable decoded from cnt.
- FSM, counter and mode latch stay in the top module.

## Test plan
- AES-128, shares = FIPS-197 key 000102..0f XOR random mask, 4 words, `out_ready`=0:
  - `out_valid`=1 from cycle 5 onward, held;
  - recombined `sh_key` words 0–3 equal the key; words 4–7 are all-zero sharing;
  - mode flags 00.
- AES-256, 8 words with `in_valid` gaps of 0–3 cycles:
  - recombined key = 000102..1f;
  - `out_mode_256`=1;
  - `in_ready`=0 throughout HOLD.
- AES-192, 6 words, then `out_ready`=1 for one cycle:
  - next cycle `sh_key`=0, `out_valid`=0, `in_ready`=1;
  - a second key loads correctly.
- `flush` asserted on the 3rd input handshake of a 256 load:
  - next cycle all slots are 0 and cnt=0;
  - the following 8 words load a fresh key with no residue.
- `rst` asserted in HOLD together with `out_ready`=1:
  - all outputs return to their reset values.
- `in_mode`=11 on the first word and toggling on later words:
  - treated as 256 (8 words, `out_mode_256`=1);
  - later `in_mode` changes are ignored.
